benes_route_pipelined: RTL and testbench

//  Data-path consumer of Benes control bits: routes SIZE data lanes through a
//  (2*log2(SIZE)-1)-stage Benes swap network, driven by a per-beat control word.
//  Bit format is identical to the control-bit generator output, so out[x] = in[perm[x]]
//  for the perm that produced ctrl. Sits downstream of the generator in the xbar;

---
 rtl/benes_route_pipelined.sv | 122 ++++++++++++
 tb/tb_benes_route_pipelined.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/benes_route_pipelined.sv
// Elastic pipelined Benes swap network: routes SIZE lanes of DATA_W bits so that
// out[x] = in[perm[x]] for the permutation whose control bits accompany each beat.
module benes_route_pipelined #(
    parameter int SIZE      = 32,
    parameter int DATA_W    = 8,
    parameter int REG_EVERY = 3,
    localparam int TAGWIDTH = $clog2(SIZE),
    localparam int STAGES   = 2*TAGWIDTH-1,
    localparam int BITWIDTH = STAGES*SIZE/2,
    localparam int NREG     = (STAGES + REG_EVERY - 1) / REG_EVERY,
    localparam int HALF     = SIZE/2,
    localparam int DW       = SIZE*DATA_W
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_ctrl,
    input  logic [DW-1:0]       in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic                busy
);

    // One swap column: gap shrinks back down after the middle stage.
    function automatic logic [DW-1:0] applyStage(input logic [DW-1:0] d,
                                                 input logic [HALF-1:0] c,
                                                 input int stage);
        logic [DW-1:0] r;
        int gap;
        int pos;
        r   = d;
        gap = (stage < STAGES-1-stage) ? (1 << stage) : (1 << (STAGES-1-stage));
        for (int j = 0; j < HALF; j++) begin
            pos = (j % gap) + 2*gap*(j / gap);
            if (c[j]) begin
                r[pos*DATA_W +: DATA_W]       = d[(pos+gap)*DATA_W +: DATA_W];
                r[(pos+gap)*DATA_W +: DATA_W] = d[pos*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    logic [NREG-1:0] w_validVec;

    for (genvar k = 0; k < NREG; k++) begin : g_reg
        localparam int FIRST = k*REG_EVERY;
        localparam int LAST  = (((k+1)*REG_EVERY < STAGES) ? (k+1)*REG_EVERY : STAGES) - 1;
        localparam int NSEG  = LAST - FIRST + 1;
        localparam int CWIN  = (STAGES - FIRST)*HALF;
        localparam int CWOUT = (STAGES - 1 - LAST)*HALF;

        logic            w_upValid;
        logic [DW-1:0]   w_upData;
        logic [CWIN-1:0] w_upCtrl;
        logic            w_ready;
        logic            w_downReady;
        logic            r_valid;
        logic [DW-1:0]   r_data;

        if (k == 0) begin : g_src
            assign w_upValid = in_valid;
            assign w_upData  = in_data;
            assign w_upCtrl  = in_ctrl;
        end else begin : g_src
            assign w_upValid = g_reg[k-1].r_valid;
            assign w_upData  = g_reg[k-1].r_data;
            assign w_upCtrl  = g_reg[k-1].g_ctrl.r_ctrl;
        end

        if (k == NREG-1) begin : g_dn
            assign w_downReady = out_ready;
        end else begin : g_dn
            assign w_downReady = g_reg[k+1].w_ready;
        end

        assign w_ready = !r_valid || w_downReady;

        for (genvar s = 0; s < NSEG; s++) begin : g_st
            logic [DW-1:0] w_out;
            if (s == 0) begin : g_in
                assign w_out = applyStage(w_upData, w_upCtrl[0 +: HALF], FIRST);
            end else begin : g_in
                assign w_out = applyStage(g_st[s-1].w_out, w_upCtrl[s*HALF +: HALF], FIRST+s);
            end
        end

        // Lanes only capture real beats so idle cycles leave them untouched.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_ready) begin
                r_valid <= w_upValid;
                if (w_upValid) begin
                    r_data <= g_st[NSEG-1].w_out;
                end
            end
        end

        // Only the ctrl of stages still ahead travels with the beat.
        if (k < NREG-1) begin : g_ctrl
            logic [CWOUT-1:0] r_ctrl;
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_ctrl <= '0;
                end else if (w_ready && w_upValid) begin
                    r_ctrl <= w_upCtrl[CWIN-1 -: CWOUT];
                end
            end
        end

        assign w_validVec[k] = r_valid;
    end

    assign in_ready  = g_reg[0].w_ready;
    assign out_valid = g_reg[NREG-1].r_valid;
    assign out_data  = g_reg[NREG-1].r_data;
    assign busy      = |w_validVec;

endmodule

// File: tb/tb_benes_route_pipelined.sv
// Directed and streaming checks for benes_route_pipelined at default parameters
// (32 lanes x 8 bits, 9 swap stages, 3 pipeline registers).
module tb_benes_route_pipelined;

    localparam int SIZE   = 32;
    localparam int DATA_W = 8;
    localparam int STAGES = 9;
    localparam int HALF   = 16;
    localparam int BW     = STAGES*HALF;
    localparam int DW     = SIZE*DATA_W;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    int testsRun    = 0;
    int testsFailed = 0;

    benes_route_pipelined #(.SIZE(SIZE), .DATA_W(DATA_W), .REG_EVERY(3)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Reference network walked block-by-block rather than by pair index.
    function automatic logic [DW-1:0] routeModel(input logic [BW-1:0] c, input logic [DW-1:0] d);
        logic [DATA_W-1:0] lane [SIZE];
        logic [DATA_W-1:0] t;
        logic [DW-1:0]     r;
        int gap;
        int j;
        for (int x = 0; x < SIZE; x++) lane[x] = d[x*DATA_W +: DATA_W];
        for (int s = 0; s < STAGES; s++) begin
            gap = 1 << ((s < STAGES-1-s) ? s : STAGES-1-s);
            for (int base = 0; base < SIZE; base += 2*gap) begin
                for (int off = 0; off < gap; off++) begin
                    j = (base / (2*gap))*gap + off;
                    if (c[s*HALF + j]) begin
                        t                    = lane[base+off];
                        lane[base+off]       = lane[base+off+gap];
                        lane[base+off+gap]   = t;
                    end
                end
            end
        end
        for (int x = 0; x < SIZE; x++) r[x*DATA_W +: DATA_W] = lane[x];
        return r;
    endfunction

    function automatic logic [DW-1:0] makeLanes(input int mul, input int add);
        logic [DW-1:0] r;
        for (int x = 0; x < SIZE; x++) r[x*DATA_W +: DATA_W] = 8'((x*mul + add) & 255);
        return r;
    endfunction

    function automatic logic [DW-1:0] xorLanes(input logic [DW-1:0] d, input int c);
        logic [DW-1:0] r;
        for (int x = 0; x < SIZE; x++) r[x*DATA_W +: DATA_W] = d[(x ^ c)*DATA_W +: DATA_W];
        return r;
    endfunction

    function automatic logic [BW-1:0] stageOnes(input int s);
        logic [BW-1:0] r;
        r = '0;
        r[s*HALF +: HALF] = '1;
        return r;
    endfunction

    function automatic logic [BW-1:0] randCtrl();
        logic [BW-1:0] r;
        for (int i = 0; i < BW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] r;
        for (int x = 0; x < SIZE; x++) r[x*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    // Single beat with free-flowing output; checks acceptance, latency and routing.
    task automatic applyStimulus(input string tag, input logic [BW-1:0] c,
                                 input logic [DW-1:0] d, input logic [DW-1:0] expected);
        int cnt;
        in_ctrl   = c;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_inready"}, DW'(in_ready), DW'(1));
        @(posedge clk) #1;
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(posedge clk) #1;
            cnt++;
        end
        checkOutput({tag, "_latency"}, DW'(cnt), DW'(3));
        checkOutput({tag, "_data"}, out_data, expected);
        @(posedge clk) #1;
    endtask

    // Stream monitor: scoreboard of accepted beats against emitted beats.
    bit            monOn = 1'b0;
    int            cycleCnt, accepts, outCount, firstOut, lastOut;
    logic [DW-1:0] q[$];

    always @(negedge clk) begin
        if (!monOn) begin
            cycleCnt = 0;
            accepts  = 0;
            outCount = 0;
            firstOut = -1;
            lastOut  = -1;
            q.delete();
        end else begin
            cycleCnt++;
            if (in_valid && in_ready) begin
                q.push_back(routeModel(in_ctrl, in_data));
                accepts++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) checkOutput("stream_unexpected", DW'(1), DW'(0));
                else               checkOutput("stream_data", out_data, q.pop_front());
                outCount++;
                if (firstOut < 0) firstOut = cycleCnt;
                lastOut = cycleCnt;
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] snap;
        int            stalls;
        int            nAcc;
        bit            acc;

        n_rst     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        #2;
        checkOutput("rst_out_valid", DW'(out_valid), DW'(0));
        checkOutput("rst_busy",      DW'(busy),      DW'(0));
        checkOutput("rst_in_ready",  DW'(in_ready),  DW'(1));
        checkOutput("rst_out_data",  out_data,       '0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk) #1;

        applyStimulus("identity", '0, makeLanes(1, 0), makeLanes(1, 0));

        d = makeLanes(7, 3);
        applyStimulus("swap0_1",  BW'(1),       d, xorLanes(d, 1) & ~DW'(0) ^ (xorLanes(d, 1) ^ {d[DW-1:16], d[7:0], d[15:8]}));
        applyStimulus("swap0_16", BW'(1) << 64, d,
                      {d[DW-1:17*8], d[7:0], d[16*8-1:8], d[17*8-1:16*8]});

        // Whole-column swaps flip one index bit: out[x] = in[x ^ c].
        applyStimulus("reverse", stageOnes(0) | stageOnes(1) | stageOnes(2) | stageOnes(3) | stageOnes(4),
                      d, xorLanes(d, 31));
        applyStimulus("reverse_late", stageOnes(4) | stageOnes(5) | stageOnes(6) | stageOnes(7) | stageOnes(8),
                      makeLanes(5, 3), xorLanes(makeLanes(5, 3), 31));
        applyStimulus("xor5",  stageOnes(0) | stageOnes(2), d, xorLanes(d, 5));
        applyStimulus("xor10", stageOnes(5) | stageOnes(7), d, xorLanes(d, 10));
        applyStimulus("xor17", stageOnes(8) | stageOnes(4), d, xorLanes(d, 17));

        // Eight back-to-back beats with random ctrl and data.
        out_ready = 1'b1;
        monOn     = 1'b1;
        stalls    = 0;
        for (int i = 0; i < 8; i++) begin
            in_ctrl  = randCtrl();
            in_data  = randData();
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) stalls++;
            @(posedge clk) #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && outCount < 8; i++) @(posedge clk) #1;
        checkOutput("b2b_stalls",   DW'(stalls),            DW'(0));
        checkOutput("b2b_accepts",  DW'(accepts),           DW'(8));
        checkOutput("b2b_outcount", DW'(outCount),          DW'(8));
        checkOutput("b2b_span",     DW'(lastOut - firstOut), DW'(7));
        monOn = 1'b0;
        @(posedge clk) #1;

        // Backpressure: downstream stalled while the source keeps offering.
        out_ready = 1'b0;
        monOn     = 1'b1;
        nAcc      = 0;
        snap      = '0;
        in_ctrl   = randCtrl();
        in_data   = randData();
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk) #1;
            if (acc) begin
                nAcc++;
                in_ctrl = randCtrl();
                in_data = randData();
            end
            if (i == 3) snap = out_data;
        end
        checkOutput("stall_accepts",  DW'(nAcc),      DW'(3));
        checkOutput("stall_in_ready", DW'(in_ready),  DW'(0));
        checkOutput("stall_valid",    DW'(out_valid), DW'(1));
        checkOutput("stall_stable",   out_data,       snap);
        checkOutput("stall_head",     out_data,       (q.size() > 0) ? q[0] : '0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && outCount < 3; i++) @(posedge clk) #1;
        checkOutput("drain_outcount", DW'(outCount), DW'(3));
        checkOutput("drain_empty",    DW'(q.size()), DW'(0));
        monOn = 1'b0;
        @(posedge clk) #1;

        // Reset with two beats in flight.
        in_ctrl  = randCtrl();
        in_data  = randData();
        in_valid = 1'b1;
        @(posedge clk) #1;
        in_ctrl  = randCtrl();
        in_data  = randData();
        @(posedge clk) #1;
        in_valid = 1'b0;
        checkOutput("flight_busy", DW'(busy), DW'(1));
        #2 n_rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", DW'(out_valid), DW'(0));
        checkOutput("midrst_busy",      DW'(busy),      DW'(0));
        checkOutput("midrst_out_data",  out_data,       '0);
        checkOutput("midrst_in_ready",  DW'(in_ready),  DW'(1));
        @(posedge clk) #1 n_rst = 1'b1;
        @(posedge clk) #1;
        checkOutput("postrst_out_valid", DW'(out_valid), DW'(0));
        applyStimulus("postrst_xor5", stageOnes(0) | stageOnes(2), d, xorLanes(d, 5));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
